instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Byte-serial instruction fetch engine for the multi-cycle CPU. On a fetch request it reads four consecutive bytes from the byte-wide synchronous instruction memory and assembles them big-endian into a 32-bit word. It presents that word on IDataOut with a one-cycle IRWre strobe, which is the write interface consumed by the instruction register. It sits between the control unit's IF state, the PC, and instruction memory.

## Interface
Parameters:
- ADDR_W, 32, width of the fetch and memory addresses; all address arithmetic is modulo 2^ADDR_W.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- FetchReq  in  1  fetch request; sampled only in IDLE.
- FetchAddr  in  ADDR_W  byte address of the instruction; sampled with FetchReq.
- Abort  in  1  synchronous cancel of an in-flight fetch.
- MemRd  out  1  memory read strobe.
- MemAddr  out  ADDR_W  byte address presented with MemRd.
- MemData  in  8  memory read data, valid the cycle after MemRd.
- IDataOut  out  32  assembled instruction; holds its value between completed fetches.
- IRWre  out  1  one-cycle strobe: IDataOut is new and valid this cycle.
- Busy  out  1  high whenever state is not IDLE.
- AddrErr  out  1  one-cycle strobe: the request address was misaligned.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE, ERR.
- IDLE: on FetchReq=1 with FetchAddr[1:0]=0, latch the base address A, clear the byte counter k, and go to ISSUE. On FetchReq=1 with FetchAddr[1:0]!=0, go to ERR without issuing any memory read.
- ISSUE:
  - MemRd=1 and MemAddr=A+k, for k=0..3.
  - Each cycle, capture MemData from the previous cycle's read (byte k-1) into the shift register.
  - After k=3, go to DRAIN.
- DRAIN: MemRd=0. Capture byte 3, then go to DONE.
- Byte order: IDataOut = {byte@A, byte@A+1, byte@A+2, byte@A+3}, so byte@A occupies bits [31:24].
- DONE: IRWre=1 and IDataOut is updated to the assembled word in the same cycle. Next state is IDLE.
- ERR: AddrErr=1 for one cycle, IRWre=0, IDataOut unchanged. Next state is IDLE.
- Requests in any state other than IDLE are ignored, including the DONE and ERR cycles. The requester must hold FetchReq or re-issue it.
- Abort=1 in ISSUE or DRAIN:
  - Next state is IDLE; the partial word is discarded.
  - No IRWre is produced and IDataOut is unchanged.
  - MemRd drops in the next cycle.
- Abort is ignored in IDLE, DONE and ERR.
- Priority: Reset > Abort > normal transitions.
- Reset, including mid-fetch: state returns to IDLE and the partial word is discarded.
- Reset values: MemRd=0, MemAddr=0, IDataOut=0, IRWre=0, Busy=0, AddrErr=0.
- Outputs are registered. MemAddr shows 0 whenever MemRd=0.

## Timing
- Cycle 0: FetchReq is sampled in IDLE.
- Cycles 1–4: MemRd=1, MemAddr=A, A+1, A+2, A+3.
- Cycles 2–5: MemData carries bytes 0–3.
- Cycle 6: IRWre=1 with the new IDataOut.
- Cycle 7: IDLE. The earliest next accepted request is sampled in cycle 7, so the back-to-back period is 7 cycles.
- Busy=1 in cycles 1–6.
- Misaligned request: AddrErr=1 and Busy=1 in cycle 1, IDLE in cycle 2.
- Abort sampled in cycle n (1–5): IDLE in cycle n+1 with Busy=0.
- Address wrap: A+k is computed modulo 2^ADDR_W. With ADDR_W<32, an aligned base at the top of the address space stays in range.

## Test plan
- Reset, then check all outputs are 0 and Busy=0.
- Memory byte[0x10..0x13]=8'h12,8'h34,8'h56,8'h78, FetchReq with FetchAddr=0x10 -> MemAddr reads 0x10..0x13 in cycles 1–4, IRWre=1 in cycle 6, IDataOut=32'h12345678 held afterwards.
- FetchAddr=0x22 -> AddrErr=1 in cycle 1, MemRd never asserted, IRWre=0, IDataOut still 32'h12345678.
- Abort in cycle 3 of a fetch at 0x20 -> MemRd low from cycle 4, no IRWre, IDataOut unchanged, Busy=0 in cycle 4.
- FetchReq held high continuously at 0x0 then 0x4 -> fetches complete with IRWre in cycles 6 and 13. Requests presented in cycles 1–6 have no effect.
- Reset asserted in cycle 4 of a fetch -> IDLE next cycle, IDataOut=0, no IRWre. A subsequent fetch at 0x10 returns 32'h12345678 correctly.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: reads four bytes from byte-wide synchronous
// memory, assembles them big-endian and strobes the word into the IR.
module instr_fetch_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              FetchReq,
    input  logic [ADDR_W-1:0] FetchAddr,
    input  logic              Abort,
    output logic              MemRd,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [7:0]        MemData,
    output logic [31:0]       IDataOut,
    output logic              IRWre,
    output logic              Busy,
    output logic              AddrErr
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE,
        ERR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [23:0]       byte_sr;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (FetchReq) begin
                    if (FetchAddr[1:0] == 2'b00) begin
                        state_d = ISSUE;
                        base_d  = FetchAddr;
                        k_d     = 2'd0;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ISSUE: begin
                if (Abort) begin
                    state_d = IDLE;
                end else if (k_q == 2'd3) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            DRAIN:   state_d = Abort ? IDLE : DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            k_q      <= 2'd0;
            base_q   <= '0;
            MemRd    <= 1'b0;
            MemAddr  <= '0;
            IDataOut <= 32'd0;
            IRWre    <= 1'b0;
            Busy     <= 1'b0;
            AddrErr  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            MemRd   <= (state_d == ISSUE);
            MemAddr <= (state_d == ISSUE) ? base_d + ADDR_W'(k_d) : '0;
            IRWre   <= (state_d == DONE);
            Busy    <= (state_d != IDLE);
            AddrErr <= (state_d == ERR);
            if (state_q == DRAIN && state_d == DONE) begin
                IDataOut <= {byte_sr, MemData};
            end
        end
    end

    // Byte k-1 arrives while byte k is being requested; k=0 has nothing to capture yet.
    always_ff @(posedge CLK) begin
        if (state_q == ISSUE && k_q != 2'd0) begin
            byte_sr <= {byte_sr[15:0], MemData};
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a byte memory model plus a
// per-fetch timeline model of expected outputs, checked every cycle.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        FetchReq;
    logic [31:0] FetchAddr;
    logic        Abort;
    logic        MemRd;
    logic [31:0] MemAddr;
    logic [7:0]  MemData;
    logic [31:0] IDataOut;
    logic        IRWre;
    logic        Busy;
    logic        AddrErr;

    logic [7:0]  mem [0:255];
    logic [31:0] exp_word;
    int          total = 0;
    int          bad = 0;

    localparam int K_NORM  = 0;
    localparam int K_ABORT = 1;
    localparam int K_RST   = 2;

    instr_fetch_unit #(.ADDR_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .FetchReq(FetchReq), .FetchAddr(FetchAddr),
        .Abort(Abort), .MemRd(MemRd), .MemAddr(MemAddr), .MemData(MemData),
        .IDataOut(IDataOut), .IRWre(IRWre), .Busy(Busy), .AddrErr(AddrErr)
    );

    always #5 CLK = ~CLK;

    initial MemData = 8'd0;
    always @(posedge CLK) begin
        if (MemRd) MemData <= mem[MemAddr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " MemRd"},    {31'd0, MemRd},   32'd0);
        chk({tag, " MemAddr"},  MemAddr,          32'd0);
        chk({tag, " IRWre"},    {31'd0, IRWre},   32'd0);
        chk({tag, " Busy"},     {31'd0, Busy},    32'd0);
        chk({tag, " AddrErr"},  {31'd0, AddrErr}, 32'd0);
        chk({tag, " IDataOut"}, IDataOut,         exp_word);
    endtask

    // One request at address a presented in cycle 0. kind/n select an abort or
    // reset in cycle n. busy_mode: 0 quiet, 1 hold FetchReq at hold_a, 2 random requests.
    task automatic run_op(input int kind, input logic [31:0] a, input int n,
                          input int busy_mode, input logic [31:0] hold_a);
        logic        mis;
        logic [7:0]  b;
        logic [31:0] w;
        int          last;
        logic        e_rd, e_irw, e_busy, e_err;
        logic [31:0] e_addr;
        string       tag;
        mis = (a[1:0] != 2'b00);
        b = a[7:0];
        w = {mem[b], mem[b + 8'd1], mem[b + 8'd2], mem[b + 8'd3]};
        if (mis) last = 1;
        else if (kind == K_ABORT && n <= 5) last = n;
        else if (kind == K_RST) last = n;
        else last = 6;

        FetchReq = 1'b1; FetchAddr = a; Abort = 1'b0; Reset = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            @(posedge CLK); #1;
            if (c <= last) begin
                case (busy_mode)
                    1: begin FetchReq = 1'b1; FetchAddr = hold_a; end
                    2: begin FetchReq = 1'($urandom % 2); FetchAddr = $urandom; end
                    default: begin FetchReq = 1'b0; end
                endcase
                Abort = 1'b0;
                Reset = 1'b0;
                if (kind == K_ABORT && c == n) Abort = 1'b1;
                if (kind == K_RST && c == n) begin Reset = 1'b1; Abort = 1'($urandom % 2); end
                // Abort is meaningless in ERR and DONE; throw some in there.
                if (busy_mode == 2 && (mis || c == 6) && !(kind == K_RST && c == n))
                    Abort = 1'($urandom % 2);
            end else begin
                FetchReq = 1'b0; Abort = 1'b0; Reset = 1'b0;
            end
            @(negedge CLK);
            e_busy = (c <= last);
            e_err  = mis && c == 1;
            e_rd   = !mis && e_busy && c <= 4;
            e_addr = e_rd ? a + 32'(c - 1) : 32'd0;
            e_irw  = !mis && e_busy && c == 6;
            if (e_irw) exp_word = w;
            if (kind == K_RST && c == n + 1) exp_word = 32'd0;
            tag = $sformatf("a=%h k=%0d n=%0d c=%0d", a, kind, n, c);
            chk({tag, " MemRd"},    {31'd0, MemRd},   {31'd0, e_rd});
            chk({tag, " MemAddr"},  MemAddr,          e_addr);
            chk({tag, " IRWre"},    {31'd0, IRWre},   {31'd0, e_irw});
            chk({tag, " Busy"},     {31'd0, Busy},    {31'd0, e_busy});
            chk({tag, " AddrErr"},  {31'd0, AddrErr}, {31'd0, e_err});
            chk({tag, " IDataOut"}, IDataOut,         exp_word);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          kind, n, mode;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
        exp_word = 32'd0;
        FetchReq = 1'b0; FetchAddr = 32'd0; Abort = 1'b0;
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_idle("reset");
        Reset = 1'b0;

        run_op(K_NORM, 32'h10, 0, 0, 32'h0);
        chk("word 0x10", IDataOut, 32'h12345678);
        run_op(K_NORM, 32'h22, 0, 0, 32'h0);
        chk("after misaligned", IDataOut, 32'h12345678);
        run_op(K_ABORT, 32'h20, 3, 0, 32'h0);
        chk("after abort", IDataOut, 32'h12345678);
        run_op(K_NORM, 32'h0, 0, 1, 32'h4);
        run_op(K_NORM, 32'h4, 0, 1, 32'h4);
        run_op(K_RST, 32'h10, 4, 0, 32'h0);
        chk("after reset mid-fetch", IDataOut, 32'h0);
        run_op(K_NORM, 32'h10, 0, 0, 32'h0);
        chk("refetch 0x10", IDataOut, 32'h12345678);
        run_op(K_NORM, 32'hFFFF_FFFC, 0, 2, 32'h0);
        run_op(K_ABORT, 32'h40, 6, 2, 32'h0);

        for (int t = 0; t < 300; t++) begin
            a = $urandom;
            if ($urandom % 4 != 0) a[1:0] = 2'b00;
            kind = int'($urandom % 3);
            n = (kind == K_RST) ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 6));
            mode = int'($urandom % 3);
            if (a[1:0] != 2'b00) kind = K_NORM;
            run_op(kind, a, n, mode, $urandom);
            if ($urandom % 5 == 0) begin
                FetchReq = 1'b0;
                @(negedge CLK);
                chk_idle("idle gap");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
